pow2_approx_pipe: RTL

- Pipelined Mitchell-style antilog unit. Computes out ≈ 2^in on fixed-point data.
- Sits directly downstream of the log2 approximator. Completes the log-domain path: log2 → add/subtract in log domain → pow2_approx_pipe.
- Uses the same Q format as log2: FIX_POINT_WIDTH bits total, Bf fractional bits.
- Two-stage pipeline with valid/ready handshake and full backpressure.

---
 rtl/pow2_approx_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pow2_approx_pipe.sv
// pow2_approx_pipe: two-stage Mitchell antilog, out ~= 2^in, Q(W-Bf).Bf.
// Build option: POW2_APPROX_ROUND_EN rounds half-up on right shifts.
module pow2_approx_pipe #(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] out_data,
  output logic                       out_sat
);

  localparam int W  = FIX_POINT_WIDTH;
  localparam int KW = W - Bf;
  localparam int MW = Bf + 2;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [Bf:0]   m;
    logic          ovf;
    logic          unf;
  } s1_t;

  logic          s1_valid;
  logic          s2_valid;
  logic          ready1;
  logic          ready2;
  s1_t           s1_d;
  s1_t           s1_q;
  logic [W-1:0]  res_d;
  logic          sat_d;
  logic [W-1:0]  data_q;
  logic          sat_q;

  logic signed [KW-1:0] k_in;
  logic signed [KW-1:0] k_s;
  logic                 neg;
  logic [KW-1:0]        sh_l;
  logic [KW-1:0]        sh_r;
  logic [W-1:0]         m_w;
  logic [W-1:0]         shl_res;
  logic [W-1:0]         shr_res;

  assign ready2    = !s2_valid || out_ready;
  assign ready1    = !s1_valid || ready2;
  assign in_ready  = ready1;
  assign out_valid = s2_valid;
  assign out_data  = data_q;
  assign out_sat   = sat_q;

  assign k_in = $signed(in_data[W-1:Bf]);

  // Split the exponent into integer shift and mantissa, flag range
  always_comb begin
    s1_d     = '0;
    s1_d.k   = in_data[W-1:Bf];
    s1_d.m   = {1'b1, in_data[Bf-1:0]};
    s1_d.ovf = int'(k_in) >= KW;
    s1_d.unf = int'(k_in) < -(Bf + 1);
  end

  assign k_s     = $signed(s1_q.k);
  assign neg     = k_s[KW-1];
  assign sh_l    = s1_q.k;
  assign sh_r    = ~s1_q.k + KW'(1);
  assign m_w     = W'(s1_q.m);
  assign shl_res = m_w << sh_l;

`ifdef POW2_APPROX_ROUND_EN
  logic [MW-1:0] half;
  logic [MW-1:0] sum;

  assign half    = MW'(1) << (sh_r - KW'(1));
  assign sum     = {1'b0, s1_q.m} + half;
  assign shr_res = W'(sum >> sh_r);
`else
  assign shr_res = W'(s1_q.m >> sh_r);
`endif

  // Pick saturate, flush-to-zero or the shifted mantissa
  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    unique case (1'b1)
      s1_q.ovf: begin
        res_d = '1;
        sat_d = 1'b1;
      end
      s1_q.unf: res_d = '0;
      !neg && !s1_q.ovf: res_d = shl_res;
      neg && !s1_q.unf:  res_d = shr_res;
      default: ;
    endcase
  end

  // Stage 1 register: captures the decoded input word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (ready1) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2 register: holds the result until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      data_q   <= '0;
      sat_q    <= 1'b0;
    end else if (ready2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_q <= res_d;
        sat_q  <= sat_d;
      end
    end
  end

endmodule
